// File: rtl/product_accumulator.sv
// Accumulates multiplier products into groups of up to LEN terms and presents
// each group sum, term count and sticky carry flag on a registered valid/ready port.
module product_accumulator #(
    parameter int PROD_W = 10,
    parameter int LEN    = 8,
    parameter int ACC_W  = 13,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               out_ovf_q, out_ovf_d;

    logic [ACC_W:0]     nxt;
    logic [CNT_W-1:0]   cnt_inc;
    logic               ovf_new;
    logic               close;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        // One extra bit on the adder catches the carry out of the accumulator.
        nxt     = {1'b0, acc_q} + (ACC_W+1)'(in_prod);
        cnt_inc = cnt_q + CNT_W'(1);
        ovf_new = ovf_q | nxt[ACC_W];
        close   = (cnt_inc == CNT_W'(LEN)) || in_last;

        case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    if (close) begin
                        out_sum_d   = nxt[ACC_W-1:0];
                        out_count_d = cnt_inc;
                        out_ovf_d   = ovf_new;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        ovf_d       = 1'b0;
                        state_d     = HOLD;
                    end else begin
                        acc_d = nxt[ACC_W-1:0];
                        cnt_d = cnt_inc;
                        ovf_d = ovf_new;
                    end
                end
            end
            HOLD: begin
                // Result fields stay as-is after the transfer; only valid drops.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: a wide (13-bit) and a narrow (10-bit) instance
// share one input stream; a monitor checks each result against a queued reference.
module tb_product_accumulator;

    localparam int PW  = 10;
    localparam int LEN = 8;
    localparam int AW  = 13;
    localparam int AWO = 10;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b1;
    logic [PW-1:0] in_prod = '0;

    logic          in_ready, out_valid, out_ovf;
    logic [AW-1:0] out_sum;
    logic [CW-1:0] out_count;
    logic           o_in_ready, o_out_valid, o_out_ovf;
    logic [AWO-1:0] o_out_sum;
    logic [CW-1:0]  o_out_count;

    always #5 clk = ~clk;

    product_accumulator #(.PROD_W(PW), .LEN(LEN), .ACC_W(AW), .CNT_W(CW)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count),
        .out_ovf(out_ovf)
    );

    product_accumulator #(.PROD_W(PW), .LEN(LEN), .ACC_W(AWO), .CNT_W(CW)) u_narrow (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_in_ready),
        .in_prod(in_prod), .in_last(in_last), .out_valid(o_out_valid),
        .out_ready(out_ready), .out_sum(o_out_sum), .out_count(o_out_count),
        .out_ovf(o_out_ovf)
    );

    typedef struct {
        int unsigned sum;
        int unsigned cnt;
        int unsigned ovf;
    } exp_t;

    exp_t        q_wide[$];
    exp_t        q_narrow[$];
    int          total = 0;
    int          bad = 0;
    int unsigned grp_sum = 0;
    int unsigned grp_cnt = 0;
    int          or_mode = 0;
    bit          lat_chk = 0;
    bit          timeout_flag = 0;
    bit          end_req = 0;
    bit          end_ack = 0;

    // Reference: the true group total, reduced to the result width; any excess
    // over 2^w means a carry left the accumulator at some point in the group.
    function automatic exp_t model(int unsigned s, int unsigned c, int w);
        exp_t        e;
        int unsigned lim;
        lim   = 32'd1 << w;
        e.sum = s % lim;
        e.cnt = c;
        e.ovf = (s >= lim) ? 1 : 0;
        return e;
    endfunction

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: invariants every cycle, scoreboard pop on each transfer.
    logic          rst_prev = 1'b1;
    bit            hold_prev = 0;
    logic [AW-1:0] h_sum;
    logic [CW-1:0] h_cnt;
    logic          h_ovf;

    always @(negedge clk) begin
        exp_t e;
        if (timeout_flag) begin
            total++;
            bad++;
            $display("FAIL handshake_timeout at %0t", $time);
            timeout_flag = 0;
        end
        if (rst) begin
            hold_prev = 0;
        end else begin
            if (rst_prev) begin
                chk("reset_out_valid", out_valid, 0);
                chk("reset_out_sum", out_sum, 0);
                chk("reset_out_count", out_count, 0);
                chk("reset_out_ovf", out_ovf, 0);
                chk("reset_in_ready", in_ready, 1);
            end
            chk("in_ready_vs_valid", in_ready, !out_valid);
            chk("lockstep_ready", o_in_ready, in_ready);
            chk("lockstep_valid", o_out_valid, out_valid);
            if (lat_chk) begin
                chk("close_latency", out_valid, 1);
                lat_chk = 0;
            end
            if (hold_prev) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_sum", out_sum, h_sum);
                chk("hold_count", out_count, h_cnt);
                chk("hold_ovf", out_ovf, h_ovf);
            end
            if (out_valid && out_ready) begin
                if (q_wide.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got sum=%0d with no group pending", out_sum);
                end else begin
                    e = q_wide.pop_front();
                    chk("wide_sum", out_sum, e.sum);
                    chk("wide_count", out_count, e.cnt);
                    chk("wide_ovf", out_ovf, e.ovf);
                end
            end
            if (o_out_valid && out_ready) begin
                if (q_narrow.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_narrow_output: got sum=%0d with no group pending", o_out_sum);
                end else begin
                    e = q_narrow.pop_front();
                    chk("narrow_sum", o_out_sum, e.sum);
                    chk("narrow_count", o_out_count, e.cnt);
                    chk("narrow_ovf", o_out_ovf, e.ovf);
                end
            end
            hold_prev = out_valid && !out_ready;
            h_sum = out_sum;
            h_cnt = out_count;
            h_ovf = out_ovf;
        end
        rst_prev = rst;
        if (end_req && !end_ack) begin
            chk("wide_drained", q_wide.size(), 0);
            chk("narrow_drained", q_narrow.size(), 0);
            end_ack = 1;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int unsigned p, input bit last, input int gap);
        bit acc;
        int n;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_prod  = PW'(p);
        in_last  = last;
        acc = 0;
        n   = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            n++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!acc) begin
            timeout_flag = 1;
        end else begin
            grp_sum += p;
            grp_cnt++;
            if (last || grp_cnt == LEN) begin
                q_wide.push_back(model(grp_sum, grp_cnt, AW));
                q_narrow.push_back(model(grp_sum, grp_cnt, AWO));
                grp_sum = 0;
                grp_cnt = 0;
                lat_chk = 1;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        grp_sum = 0;
        grp_cnt = 0;
        q_wide.delete();
        q_narrow.delete();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q_wide.size() != 0 || q_narrow.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        if (q_wide.size() != 0 || q_narrow.size() != 0) timeout_flag = 1;
    endtask

    initial begin
        repeat (2) tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) send(484, 0, 0);
        drain();

        send(484, 0, 0); send(341, 0, 0); send(115, 0, 0); send(140, 0, 0); send(0, 1, 0);
        for (int i = 0; i < 8; i++) send(961, 0, 0);
        drain();

        or_mode = 1;
        send(100, 0, 0);
        send(200, 1, 0);
        repeat (3) tick();
        or_mode = 0;
        drain();

        send(341, 0, 0); send(341, 0, 2); send(341, 1, 2);
        drain();

        send(484, 0, 0); send(341, 0, 0);
        do_reset();
        send(115, 1, 0);
        drain();

        or_mode = 1;
        send(50, 1, 0);
        tick();
        do_reset();
        or_mode = 0;
        repeat (3) tick();

        send(961, 0, 0); send(961, 1, 0); send(5, 1, 0);
        drain();

        or_mode = 2;
        for (int i = 0; i < 400; i++) begin
            int unsigned a, b;
            a = $urandom_range(0, 31);
            b = $urandom_range(0, 31);
            send(a * b, ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end
        or_mode = 0;
        drain();

        end_req = 1;
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Sits directly downstream of the 5x5 Wallace-tree multiplier (`wallace_tree_reduction`). Consumes its 10-bit product P, one product per valid/ready beat.
- Sums products into groups; each group is a dot product of up to LEN terms.
- Presents each group sum through a registered valid/ready output port.
- A group closes when LEN beats have been accepted or a beat carries in_last.

Parameters:
- PROD_W, 10, product width (2x the 5-bit operand width).
- LEN, 8, maximum products per group; LEN >= 1.
- ACC_W, 13, accumulator/result width; default = PROD_W + clog2(LEN), which cannot overflow.
- CNT_W, 4, beat-counter width = clog2(LEN+1).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_prod/in_last valid this cycle.
- in_ready  output  1  block can accept a product this cycle.
- in_prod  input  PROD_W  unsigned product from multiplier P.
- in_last  input  1  closes the current group after this beat.
- out_valid  output  1  out_sum/out_count/out_ovf valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  ACC_W  group sum, modulo 2^ACC_W.
- out_count  output  CNT_W  number of products in the group, 1..LEN.
- out_ovf  output  1  sticky: carry out of ACC_W occurred during the group.

Behaviour:
- Reset (synchronous; rst sampled high at an edge):
  - state=ACCUM; acc, cnt and ovf cleared.
  - out_valid=0, out_sum=0, out_count=0, out_ovf=0.
  - in_ready=1 from the first cycle after reset release.
  - rst overrides all other inputs.
- Handshakes:
  - Input beat accepted iff in_valid && in_ready at the edge.
  - Output transfer iff out_valid && out_ready at the edge.
  - in_ready = (state==ACCUM); combinational from state only.
  - out_valid is a register and never depends on out_ready.
- States:
  - ACCUM, on accepted beat:
    - nxt = acc + zero-extend(in_prod).
    - ovf |= carry out of bit ACC_W-1.
    - cnt+1.
    - If (cnt+1==LEN) or in_last: load out_sum=nxt[ACC_W-1:0], out_count=cnt+1, out_ovf=new ovf; set out_valid=1; clear acc/cnt/ovf; go to HOLD.
    - Otherwise acc=nxt and remain in ACCUM.
    - No accepted beat: all state unchanged.
  - HOLD:
    - in_ready=0.
    - out_sum, out_count, out_ovf and out_valid held stable until transfer.
    - On transfer: out_valid=0 and return to ACCUM; out_sum/out_count/out_ovf keep their last values.
- Latency: result visible in the cycle after the edge that accepted the closing beat.
- Throughput: one cycle per accepted beat. After each group there is at least one cycle with in_ready=0 (the HOLD cycle, even with out_ready held high).
- Boundaries:
  - in_last on the first beat gives out_count=1 and out_sum=in_prod.
  - in_last on beat LEN is the same as reaching LEN.
  - in_prod=0 beats still count.
  - in_last is ignored unless its beat is accepted.
  - Overflow (only possible when ACC_W < default): the sum wraps modulo 2^ACC_W and out_ovf=1 for that group only. ovf clears when the group closes.
  - in_valid gaps do not affect acc or cnt.
  - Reset mid-group or during HOLD discards the partial group or pending result; no output is produced for it.
- Width rules: all arithmetic is unsigned; in_prod is zero-extended to ACC_W+1 for the carry.

Test Plan:
- Full group: reset, then 8 back-to-back beats of in_prod=484 (22*22), out_ready=1 -> one cycle after beat 8: out_valid=1, out_sum=3872, out_count=8, out_ovf=0; in_ready=0 for exactly that cycle.
- Early close: products 484, 341, 115, 140, 0 with in_last on the 5th beat -> out_sum=1080, out_count=5. Next group 961 x8 -> out_sum=7688.
- Backpressure: close a group while out_ready=0 for 3 cycles -> out_valid, out_sum and out_count stable, in_ready=0 throughout. The transfer occurs on the cycle out_ready=1; ACCUM follows.
- Gapped input: 3 beats of 341 with 2-cycle in_valid gaps between them, in_last on the 3rd -> out_sum=1023, out_count=3; no output during the gaps.
- Reset mid-group: accept 484 and 341, assert rst for 1 cycle, then send 115 with in_last -> out_sum=115, out_count=1. Also assert rst during HOLD -> out_valid drops to 0 with no transfer.
- Overflow (ACC_W=10, CNT_W=4): beats 961, 961 with in_last on the 2nd -> out_sum=898, out_ovf=1. Next group 5 with in_last -> out_sum=5, out_ovf=0.
